// File: rtl/gray_burst_arbiter.sv
// Round-robin owner of a shared external 3-bit gray counter: clears it, steps it Len+1 times,
// then reports the final gray value and wrap flag for one cycle.
module gray_burst_arbiter #(
   parameter int LEN_W  = 3,
   parameter int GRAY_W = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req0,
   input  logic [LEN_W-1:0]  Len0,
   input  logic              Req1,
   input  logic [LEN_W-1:0]  Len1,
   output logic              Grant0,
   output logic              Grant1,
   output logic              Busy,
   output logic              Done,
   output logic [GRAY_W-1:0] Result_Gray,
   output logic              Result_Wrap,
   output logic              Cnt_Reset,
   output logic              Cnt_En,
   input  logic [GRAY_W-1:0] Cnt_Output,
   input  logic              Cnt_Overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic               r_last;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_step;
   logic               r_grant0;
   logic               r_grant1;
   logic               r_busy;
   logic               r_clear;
   logic               r_cnt_en;
   logic               r_done;

   logic               w_pick0;
   logic               w_pick1;

   // On a tie the requester that was not served last wins.
   assign w_pick0 = Req0 & (~Req1 | r_last);
   assign w_pick1 = Req1 & (~Req0 | ~r_last);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_step   <= '0;
         r_grant0 <= 1'b0;
         r_grant1 <= 1'b0;
         r_busy   <= 1'b0;
         r_clear  <= 1'b0;
         r_cnt_en <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick0) begin
                  r_last   <= 1'b0;
                  r_len    <= Len0;
                  r_grant0 <= 1'b1;
                  r_busy   <= 1'b1;
                  r_clear  <= 1'b1;
                  r_state  <= S_CLEAR;
               end else if (w_pick1) begin
                  r_last   <= 1'b1;
                  r_len    <= Len1;
                  r_grant1 <= 1'b1;
                  r_busy   <= 1'b1;
                  r_clear  <= 1'b1;
                  r_state  <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_clear  <= 1'b0;
               r_cnt_en <= 1'b1;
               r_step   <= '0;
               r_state  <= S_RUN;
            end
            S_RUN: begin
               if (r_step == r_len) begin
                  r_cnt_en <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            S_DONE: begin
               r_done   <= 1'b0;
               r_grant0 <= 1'b0;
               r_grant1 <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // The counter's final value only settles on the edge entering DONE, so results pass through.
   assign Result_Gray = r_done ? Cnt_Output : '0;
   assign Result_Wrap = r_done & Cnt_Overflow;
   assign Cnt_Reset   = Reset | r_clear;
   assign Cnt_En      = r_cnt_en;
   assign Grant0      = r_grant0;
   assign Grant1      = r_grant1;
   assign Busy        = r_busy;
   assign Done        = r_done;

endmodule
